prng_lfsr_multi: RTL and testbench
==================================

// Module: prng_lfsr_multi
// PURPOSE
//  Parametrised dual-LFSR pseudo-random word generator, successor to the 8-bit demo generator.
//  Supports widths 8/16/24/32, three output modes including von Neumann debiasing, and a seed-load handshake.
//  Adds a repetition health check and a buffered valid/ready word output with backpressure.
//  Sits between the pad-level seed/control inputs and any downstream consumer of random bytes.
// PARAMETERS
//  WIDTH      16  LFSR width; legal values are 8, 16, 24, 32 (any other value must fail elaboration)
//  OUT_W      8   output word width in bits, 1..WIDTH
//  DEPTH      4   output FIFO entries, power of two, >=2
//  REP_LIMIT  32  run length of identical raw bits that sets health_fail, >=2
// PORTS
//  clk         in   1                   clock
//  rst         in   1                   asynchronous active-high reset
//  en          in   1                   step enable; LFSRs advance only when high
//  mode        in   2                   00 = XOR A^B, 01 = A only, 10 = von Neumann on A^B, 11 = treated as 00
//  seed_valid  in   1                   seed offer
//  seed_data   in   WIDTH               seed value
//  seed_ready  out  1                   seed accept
//  out_valid   out  1                   FIFO head valid
//  out_data    out  OUT_W               FIFO head word
//  out_ready   in   1                   consumer pops when out_valid & out_ready
//  fifo_level  out  $clog2(DEPTH)+1     FIFO occupancy
//  health_fail out  1                   sticky repetition-test failure
// BEHAVIOUR
//  Reset: A=1, B=WIDTH'hA; accumulator and bit count = 0; FIFO empty.
//   Outputs during and after reset: out_valid=0, out_data=0, fifo_level=0, health_fail=0, seed_ready=0.
//   seed_ready rises to 1 on the first clk edge after rst deasserts and stays 1 thereafter.
//  Reset mid-operation aborts everything immediately; no partial word survives.
//  LFSRs: Fibonacci, shift left, feedback = XOR of the tap bits into bit 0.
//   A taps:  W8 [7,5,4,3]   W16 [15,14,12,3]  W24 [23,22,21,16]  W32 [31,21,1,0]
//   B taps (reciprocal polynomials): W8 [7,3,2,1]  W16 [15,11,2,0]  W24 [23,6,1,0]  W32 [31,30,29,9]
//  Raw bit per step is taken from the pre-shift state: mode 01 -> A[W-1]; modes 00/11/10 -> A[W-1]^B[W-1].
//  Step condition: en & ~(seed_valid & seed_ready) & (FIFO not full, or a pop occurs this cycle).
//  FSM states:
//   IDLE: en=0.
//   RUN: stepping.
//   FULL: en=1 but stalled; LFSRs hold.
//   Transitions follow en and the full flag each cycle.
//  Mode 00/01: every step shifts one bit into the accumulator, MSB-first (first bit lands in out_data[OUT_W-1]).
//  Mode 10: steps are paired (first, second).
//   01 emits 0, 10 emits 1, 00 and 11 emit nothing.
//   An unpaired first bit is held across stalls.
//  Word completion: on the OUT_W-th emitted bit the word is pushed to the FIFO.
//   out_valid rises the following cycle, giving latency OUT_W steps + 1 cycle.
//  FIFO: show-ahead. Simultaneous push and pop at full or empty are both legal.
//   On a simultaneous push and pop, fifo_level is unchanged.
//  Seed load (seed_valid & seed_ready): A <= seed_data, B <= ~seed_data.
//   A seed of all-zero loads A=1 instead.
//   A seed of all-ones loads B=WIDTH'hA instead.
//   A seed load flushes the accumulator, the von Neumann pair state and the FIFO, and clears health_fail.
//   No step occurs in the load cycle.
//  Mode change takes effect on the next step. The accumulator is not flushed; the von Neumann pair state is cleared.
//  Health check: run counter of identical raw bits. If the count reaches REP_LIMIT, health_fail=1 (sticky).
//   health_fail is cleared only by reset or by a seed load.
//  Words keep flowing while health_fail=1; the flag is advisory.
// TESTING
//  W8/OUT_W8, seed 8'h01, mode 01, en=1, out_ready=1 -> first word 8'h01 (states 01,02,04,08,11,23,47,8E).
//  Same setup, 255 steps -> A returns to 8'h01; no state repeats earlier.
//  out_ready=0, en=1 -> fifo_level saturates at DEPTH, out_valid=1, FIFO head is stable, LFSRs hold.
//   Raising out_ready then drains DEPTH words in order.
//  Seed 0 / seed all-ones -> A=1 / B=8'h0A loaded; a seed during a stall flushes the FIFO (fifo_level=0 next cycle).
//  Mode 10 with seed 8'h01 -> emitted bits match the von Neumann reference model; no word when all pairs are equal.
//  REP_LIMIT=4, W8, mode 01, seed 8'h01 -> health_fail=1 after 4 identical MSBs; cleared by the next seed load.

Source files
------------

// File: rtl/prng_lfsr_multi.sv
// Dual-LFSR pseudo-random word generator with XOR / A-only / von Neumann output modes,
// seed-load handshake, repetition health check and a show-ahead output FIFO.
module prng_lfsr_multi #(
    parameter int WIDTH     = 16,
    parameter int OUT_W     = 8,
    parameter int DEPTH     = 4,
    parameter int REP_LIMIT = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [1:0]                 mode,
    input  logic                       seed_valid,
    input  logic [WIDTH-1:0]           seed_data,
    output logic                       seed_ready,
    output logic                       out_valid,
    output logic [OUT_W-1:0]           out_data,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic                       health_fail
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(OUT_W + 1);
    localparam int RW = $clog2(REP_LIMIT + 1);
    localparam logic [31:0] TAPS_A = (WIDTH == 8)  ? 32'h0000_00B8 :
                                     (WIDTH == 16) ? 32'h0000_D008 :
                                     (WIDTH == 24) ? 32'h00E1_0000 : 32'h8020_0003;
    localparam logic [31:0] TAPS_B = (WIDTH == 8)  ? 32'h0000_008E :
                                     (WIDTH == 16) ? 32'h0000_8805 :
                                     (WIDTH == 24) ? 32'h0080_0043 : 32'hE000_0200;
    localparam logic [WIDTH-1:0] MASK_A = TAPS_A[WIDTH-1:0];
    localparam logic [WIDTH-1:0] MASK_B = TAPS_B[WIDTH-1:0];

    generate
        if (!(WIDTH == 8 || WIDTH == 16 || WIDTH == 24 || WIDTH == 32)) begin : g_bad_width
            $error("prng_lfsr_multi: WIDTH must be 8, 16, 24 or 32");
        end
        if (OUT_W < 1 || OUT_W > WIDTH) begin : g_bad_out_w
            $error("prng_lfsr_multi: OUT_W must be 1..WIDTH");
        end
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("prng_lfsr_multi: DEPTH must be a power of two >= 2");
        end
        if (REP_LIMIT < 2) begin : g_bad_rep
            $error("prng_lfsr_multi: REP_LIMIT must be >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, FULL} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [OUT_W-1:0]   acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               vn_have_q, vn_have_d, vn_first_q, vn_first_d;
    logic [1:0]         mode_q;
    logic [RW-1:0]      run_q, run_d;
    logic               last_q, last_d, hfail_q, hfail_d, srdy_q;
    logic [OUT_W-1:0]   mem_q [DEPTH];
    logic [AW-1:0]      wptr_q, rptr_q;
    logic [AW:0]        count_q;

    logic [1:0] m;
    logic       load, pop, full, blocked, step, raw, vn_have_eff, push, emit, ebit;

    // Mode 11 aliases 00, so switching between them is not a mode change.
    assign m           = (mode == 2'b11) ? 2'b00 : mode;
    assign load        = seed_valid & srdy_q;
    assign pop         = (count_q != '0) & out_ready;
    assign full        = (count_q == (AW+1)'(DEPTH));
    assign blocked     = full & ~pop;
    assign step        = en & ~load & ~blocked;
    assign raw         = (m == 2'b01) ? a_q[WIDTH-1] : (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
    assign vn_have_eff = vn_have_q & (m == mode_q);

    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:      if (en) state_d = blocked ? FULL : RUN;
            RUN, FULL: state_d = !en ? IDLE : (blocked ? FULL : RUN);
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        a_d        = a_q;
        b_d        = b_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        vn_have_d  = vn_have_eff;
        vn_first_d = vn_first_q;
        run_d      = run_q;
        last_d     = last_q;
        hfail_d    = hfail_q;
        push       = 1'b0;
        emit       = 1'b0;
        ebit       = 1'b0;
        if (load) begin
            a_d       = (seed_data == '0) ? WIDTH'(1) : seed_data;
            b_d       = (&seed_data) ? WIDTH'(4'hA) : ~seed_data;
            acc_d     = '0;
            cnt_d     = '0;
            vn_have_d = 1'b0;
            run_d     = '0;
            hfail_d   = 1'b0;
        end else if (step) begin
            a_d    = {a_q[WIDTH-2:0], ^(a_q & MASK_A)};
            b_d    = {b_q[WIDTH-2:0], ^(b_q & MASK_B)};
            last_d = raw;
            if (run_q != '0 && raw == last_q) begin
                if (run_q != RW'(REP_LIMIT)) run_d = run_q + 1'b1;
            end else begin
                run_d = RW'(1);
            end
            if (run_d == RW'(REP_LIMIT)) hfail_d = 1'b1;
            if (m == 2'b10) begin
                if (vn_have_eff) begin
                    vn_have_d = 1'b0;
                    emit      = (vn_first_q != raw);
                    ebit      = vn_first_q;
                end else begin
                    vn_have_d  = 1'b1;
                    vn_first_d = raw;
                end
            end else begin
                emit = 1'b1;
                ebit = raw;
            end
            if (emit) begin
                acc_d = OUT_W'({acc_q, ebit});
                if (cnt_q == CW'(OUT_W - 1)) begin
                    push  = 1'b1;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q        <= WIDTH'(1);
            b_q        <= WIDTH'(4'hA);
            acc_q      <= '0;
            cnt_q      <= '0;
            vn_have_q  <= 1'b0;
            vn_first_q <= 1'b0;
            mode_q     <= 2'b00;
            run_q      <= '0;
            last_q     <= 1'b0;
            hfail_q    <= 1'b0;
            srdy_q     <= 1'b0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            a_q        <= a_d;
            b_q        <= b_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            vn_have_q  <= vn_have_d;
            vn_first_q <= vn_first_d;
            mode_q     <= m;
            run_q      <= run_d;
            last_q     <= last_d;
            hfail_q    <= hfail_d;
            srdy_q     <= 1'b1;
            if (load) begin
                wptr_q  <= '0;
                rptr_q  <= '0;
                count_q <= '0;
            end else begin
                if (push) begin
                    mem_q[wptr_q] <= acc_d;
                    wptr_q        <= wptr_q + 1'b1;
                end
                if (pop) rptr_q <= rptr_q + 1'b1;
                if (push && !pop)      count_q <= count_q + 1'b1;
                else if (pop && !push) count_q <= count_q - 1'b1;
            end
        end
    end

    assign seed_ready  = srdy_q;
    assign out_valid   = (count_q != '0);
    assign out_data    = (count_q != '0) ? mem_q[rptr_q] : '0;
    assign fifo_level  = count_q;
    assign health_fail = hfail_q;
endmodule

// File: tb/tb_prng_lfsr_multi.sv
// Scoreboard bench for prng_lfsr_multi (W8, OUT_W 8, DEPTH 4, REP_LIMIT 4) with a
// behavioural generator model feeding an expected-word queue.
module tb_prng_lfsr_multi;
    logic       clk = 1'b0;
    logic       rst, en, seed_valid, out_ready;
    logic [1:0] mode;
    logic [7:0] seed_data;
    logic       seed_ready, out_valid, health_fail;
    logic [7:0] out_data;
    logic [2:0] fifo_level;

    prng_lfsr_multi #(.WIDTH(8), .OUT_W(8), .DEPTH(4), .REP_LIMIT(4)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .seed_valid(seed_valid),
        .seed_data(seed_data), .seed_ready(seed_ready), .out_valid(out_valid),
        .out_data(out_data), .out_ready(out_ready), .fifo_level(fifo_level),
        .health_fail(health_fail)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0;
    logic [7:0] ma, mb, macc;
    int         mcnt, mrun;
    bit         mhave, mfirst, mlast, mhf, msrdy;
    logic [1:0] mprev;
    logic [7:0] q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic mdl_reset();
        ma = 8'h01; mb = 8'h0A; macc = 8'h00; mcnt = 0; mrun = 0;
        mhave = 0; mfirst = 0; mlast = 0; mhf = 0; mprev = 2'b00;
        q.delete();
    endtask

    // One clock: compare DUT state against the model, advance the model, cross the edge.
    task automatic cyc(input string tag);
        logic [1:0] mm;
        bit ld, pp, fl, st, raw, hv, emit, eb;
        logic [7:0] exp;
        pp = out_ready && (q.size() > 0);
        chk({tag, ":lvl"}, 32'(fifo_level), 32'(q.size()));
        chk({tag, ":vld"}, 32'(out_valid), 32'(q.size() > 0));
        chk({tag, ":hf"}, 32'(health_fail), 32'(mhf));
        chk({tag, ":srdy"}, 32'(seed_ready), 32'(msrdy));
        if (pp) begin
            exp = q.pop_front();
            chk({tag, ":pop"}, 32'(out_data), 32'(exp));
        end else begin
            chk({tag, ":head"}, 32'(out_data), (q.size() > 0) ? 32'(q[0]) : 32'h0);
        end
        if (rst) begin
            mdl_reset();
            msrdy = 0;
        end else begin
            mm = (mode == 2'b11) ? 2'b00 : mode;
            ld = seed_valid && msrdy;
            fl = (q.size() + (pp ? 1 : 0)) == 4;
            st = en && !ld && (!fl || pp);
            hv = mhave && (mm == mprev);
            if (ld) begin
                ma = (seed_data == 8'h00) ? 8'h01 : seed_data;
                mb = (seed_data == 8'hFF) ? 8'h0A : ~seed_data;
                macc = 0; mcnt = 0; hv = 0; mrun = 0; mhf = 0;
                q.delete();
            end else if (st) begin
                raw = (mm == 2'b01) ? ma[7] : (ma[7] ^ mb[7]);
                if (mrun > 0 && raw == mlast) mrun++;
                else mrun = 1;
                mlast = raw;
                if (mrun >= 4) mhf = 1;
                emit = 0; eb = 0;
                if (mm == 2'b10) begin
                    if (hv) begin
                        hv = 0;
                        if (mfirst != raw) begin emit = 1; eb = mfirst; end
                    end else begin
                        hv = 1; mfirst = raw;
                    end
                end else begin
                    emit = 1; eb = raw;
                end
                if (emit) begin
                    macc = {macc[6:0], eb};
                    mcnt++;
                    if (mcnt == 8) begin q.push_back(macc); mcnt = 0; end
                end
                ma = {ma[6:0], ma[7] ^ ma[5] ^ ma[4] ^ ma[3]};
                mb = {mb[6:0], mb[7] ^ mb[3] ^ mb[2] ^ mb[1]};
            end
            mhave = hv;
            mprev = mm;
            msrdy = 1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst:vld", 32'(out_valid), 32'h0);
        chk("rst:data", 32'(out_data), 32'h0);
        chk("rst:lvl", 32'(fifo_level), 32'h0);
        chk("rst:hf", 32'(health_fail), 32'h0);
        chk("rst:srdy", 32'(seed_ready), 32'h0);
        mdl_reset();
        msrdy = 0;
        cyc("rst");
        cyc("rst");
        rst = 1'b0;
        cyc("rst_rel");
        chk("srdy_up", 32'(seed_ready), 32'h1);
    endtask

    task automatic load_seed(input logic [7:0] s);
        seed_valid = 1'b1; seed_data = s;
        cyc("seed");
        seed_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; seed_valid = 1'b0; out_ready = 1'b0;
        mode = 2'b00; seed_data = 8'h00;
        mdl_reset();
        msrdy = 0;
        @(negedge clk);
        do_reset();

        // A-only stream from seed 01: health trips after 4 zero MSBs, first word is 01.
        mode = 2'b01; out_ready = 1'b1;
        load_seed(8'h01);
        en = 1'b1;
        for (int i = 0; i < 3; i++) cyc("a_only");
        chk("hf_3steps", 32'(health_fail), 32'h0);
        cyc("a_only");
        chk("hf_4steps", 32'(health_fail), 32'h1);
        for (int i = 0; i < 4; i++) cyc("a_only");
        chk("word1_vld", 32'(out_valid), 32'h1);
        chk("word1", 32'(out_data), 32'h01);
        for (int i = 0; i < 2100; i++) cyc("a_only");

        // Backpressure: saturate, then drain in order.
        out_ready = 1'b0;
        for (int i = 0; i < 60; i++) cyc("stall");
        chk("stall_lvl", 32'(fifo_level), 32'h4);
        en = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 6; i++) cyc("drain");
        chk("drain_lvl", 32'(fifo_level), 32'h0);

        // Seed of zero during a stall flushes the FIFO and clears health.
        en = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < 40; i++) cyc("stall2");
        load_seed(8'h00);
        chk("flush_lvl", 32'(fifo_level), 32'h0);
        chk("hf_clr", 32'(health_fail), 32'h0);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) cyc("seed0");
        chk("seed0_word", 32'(out_data), 32'h01);

        // All-ones seed, XOR mode.
        mode = 2'b00;
        load_seed(8'hFF);
        for (int i = 0; i < 200; i++) cyc("xor_ff");

        // von Neumann from seed 01, then mode hopping with random en/out_ready.
        mode = 2'b10;
        load_seed(8'h01);
        for (int i = 0; i < 400; i++) cyc("vn");
        for (int i = 0; i < 1500; i++) begin
            if (i % 23 == 0) mode = 2'($urandom_range(0, 3));
            en = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            if (i % 500 == 250) begin
                seed_data = 8'($urandom);
                seed_valid = 1'b1;
            end
            cyc("rand");
            seed_valid = 1'b0;
        end

        // Reset in mid-flight, then resume.
        en = 1'b1; out_ready = 1'b0; mode = 2'b01;
        for (int i = 0; i < 20; i++) cyc("pre_rst");
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) cyc("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
